// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst, INCR-hold and lock
// awareness.
//
// Ports:
//   HCLK       in   bus clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HBUSREQ    in   [NUM_MST] bus request per master
//   HLOCK      in   [NUM_MST] locked-transfer request per master
//   HTRANS     in   [2] transfer type on the bus (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST     in   [3] burst type on the bus
//   HREADY     in   combined ready
//   HRESP      in   [2] combined response (OKAY/ERROR/RETRY/SPLIT)
//   HGRANT     out  [NUM_MST] registered one-hot grant
//   HMASTER    out  [2] registered owner of the current address phase
//   HMASTLOCK  out  registered locked indication for the address phase
//
// NUM_MST is supported over 2..4.
module ahb_arbiter #(
  parameter int NUM_MST = 4
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  input  logic [1:0]         HRESP,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [1:0]         HMASTER,
  output logic               HMASTLOCK
);

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [2:0] BURST_INCR = 3'b001;

  logic [3:0]         cnt;
  logic [3:0]         cnt_nxt;
  logic               incr_hold;
  logic               incr_hold_nxt;
  logic [1:0]         ptr;
  logic [1:0]         grant_idx;
  logic [1:0]         win_idx;
  logic               win_vld;
  logic [NUM_MST-1:0] grant_nxt;
  logic               lock_hold;
  logic               owner_req;
  logic               rearb_ok;
  int                 ord;
  int                 best_ord;

  // Beats remaining after the NONSEQ beat: HBURST[2:1] selects 1/4/8/16 beats.
  function automatic logic [3:0] burst_remaining(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   burst_remaining = 4'd3;
      2'b10:   burst_remaining = 4'd7;
      2'b11:   burst_remaining = 4'd15;
      default: burst_remaining = 4'd0;
    endcase
  endfunction

  // Decode the current grant and the owner's request line.
  always_comb begin
    grant_idx = 2'd0;
    owner_req = 1'b0;
    for (int c = 0; c < NUM_MST; c++) begin
      if (HGRANT[c]) grant_idx = 2'(c);
      if (HMASTER == 2'(c)) owner_req = HBUSREQ[c];
    end
  end

  // HGRANT is one-hot, so this selects HLOCK of the granted master.
  assign lock_hold = |(HLOCK & HGRANT);

  // Round-robin: each requester's distance from ptr+1 is its search rank;
  // the lowest rank wins. No requester parks the bus on master 0.
  always_comb begin
    win_idx   = 2'd0;
    win_vld   = 1'b0;
    ord       = 0;
    best_ord  = NUM_MST;
    grant_nxt = '0;
    for (int c = 0; c < NUM_MST; c++) begin
      ord = (c + 2 * NUM_MST - int'(ptr) - 1) % NUM_MST;
      if (HBUSREQ[c] && (ord < best_ord)) begin
        best_ord = ord;
        win_idx  = 2'(c);
        win_vld  = 1'b1;
      end
    end
    for (int c = 0; c < NUM_MST; c++) begin
      grant_nxt[c] = (win_idx == 2'(c));
    end
  end

  // Beat counter: an error-class response in a wait state aborts the burst.
  always_comb begin
    cnt_nxt = cnt;
    if (!HREADY) begin
      if (HRESP != RSP_OKAY) cnt_nxt = 4'd0;
    end else begin
      case (HTRANS)
        TR_IDLE:   cnt_nxt = 4'd0;
        TR_NONSEQ: cnt_nxt = burst_remaining(HBURST);
        TR_SEQ:    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        default:   cnt_nxt = cnt;
      endcase
    end
  end

  // Undefined-length INCR keeps the bus until its owner lets go; a release
  // wins over a simultaneous new INCR start.
  always_comb begin
    incr_hold_nxt = incr_hold;
    if ((HREADY && (HTRANS == TR_IDLE)) || !owner_req) begin
      incr_hold_nxt = 1'b0;
    end else if (HREADY && (HTRANS == TR_NONSEQ) && (HBURST == BURST_INCR)) begin
      incr_hold_nxt = 1'b1;
    end
  end

  assign rearb_ok = HREADY && (cnt_nxt == 4'd0) && !incr_hold && !lock_hold;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT    <= {{(NUM_MST-1){1'b0}}, 1'b1};
      HMASTER   <= 2'd0;
      HMASTLOCK <= 1'b0;
      ptr       <= 2'd0;
      cnt       <= 4'd0;
      incr_hold <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      incr_hold <= incr_hold_nxt;
      if (rearb_ok) begin
        HGRANT <= grant_nxt;
        // A park grant leaves the pointer where it was.
        if (win_vld) ptr <= win_idx;
      end
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTLOCK <= lock_hold;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  localparam int NUM_MST = 4;

  logic       HCLK;
  logic       HRESET;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int total = 0;
  int bad   = 0;

  // Reference model state: indices and beat counts as plain integers.
  int m_grant  = 0;
  int m_ptr    = 0;
  int m_left   = 0;
  int m_master = 0;
  bit m_incr   = 0;
  bit m_mlock  = 0;

  ahb_arbiter #(.NUM_MST(NUM_MST)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance the reference model by one clock edge using the driven inputs.
  task automatic model_step();
    int  left_n;
    int  beats;
    int  win;
    int  c;
    bit  locked;
    bit  rearb;
    if (HRESET) begin
      m_grant = 0; m_ptr = 0; m_left = 0; m_master = 0; m_incr = 0; m_mlock = 0;
      return;
    end
    locked = HLOCK[m_grant];
    if (!HREADY) begin
      left_n = (HRESP != 2'b00) ? 0 : m_left;
    end else begin
      case (HTRANS)
        2'b00: left_n = 0;
        2'b01: left_n = m_left;
        2'b10: begin
          beats  = (HBURST < 3'd2) ? 1 : (1 << (int'(HBURST >> 1) + 1));
          left_n = beats - 1;
        end
        default: left_n = (m_left > 0) ? m_left - 1 : 0;
      endcase
    end
    rearb = HREADY && (left_n == 0) && !m_incr && !locked;
    if ((HREADY && HTRANS == 2'b00) || !HBUSREQ[m_master]) m_incr = 0;
    else if (HREADY && HTRANS == 2'b10 && HBURST == 3'b001) m_incr = 1;
    if (HREADY) begin
      m_master = m_grant;
      m_mlock  = locked;
    end
    if (rearb) begin
      win = -1;
      for (int k = 1; k <= NUM_MST; k++) begin
        c = (m_ptr + k) % NUM_MST;
        if (win < 0 && HBUSREQ[c]) win = c;
      end
      if (win >= 0) begin
        m_grant = win;
        m_ptr   = win;
      end else begin
        m_grant = 0;
      end
    end
    m_left = left_n;
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic [1:0] rs);
    HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rs;
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    step(4'b1111, 4'b0100, 2'b10, 3'b011, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0001) begin bad++; $display("FAIL reset_grant got=%b want=0001", HGRANT); end
    total++; if (HMASTER !== 2'd0) begin bad++; $display("FAIL reset_master got=%0d want=0", HMASTER); end
    total++; if (HMASTLOCK !== 1'b0) begin bad++; $display("FAIL reset_mastlock got=%b want=0", HMASTLOCK); end
    HRESET = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [4];
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
      total++; if (HGRANT !== seq[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, HGRANT, seq[i]); end
      total++; if (HMASTER !== 2'(i)) begin bad++; $display("FAIL rr_master[%0d] got=%0d want=%0d", i, HMASTER, i); end
    end
  endtask

  task automatic test_fixed_burst();
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_setup got=%b want=0100", HGRANT); end
    step(4'b1111, 4'b0000, 2'b10, 3'b101, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_nonseq got=%b want=0100", HGRANT); end
    for (int i = 1; i <= 7; i++) begin
      step(4'b1111, 4'b0000, 2'b11, 3'b101, 1'b1, 2'b00);
      if (i < 7) begin
        total++; if (HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_seq[%0d] got=%b want=0100", i, HGRANT); end
      end else begin
        total++; if (HGRANT !== 4'b1000) begin bad++; $display("FAIL burst_end got=%b want=1000", HGRANT); end
      end
      total++; if (HMASTER !== 2'd2) begin bad++; $display("FAIL burst_master[%0d] got=%0d want=2", i, HMASTER); end
    end
  endtask

  task automatic test_wait_states();
    step(4'b1111, 4'b0000, 2'b10, 3'b011, 1'b1, 2'b00);
    for (int i = 0; i < 2; i++) begin
      step(4'b1111, 4'b0000, 2'b11, 3'b011, 1'b0, 2'b00);
      total++; if (HGRANT !== 4'b1000) begin bad++; $display("FAIL wait_grant[%0d] got=%b want=1000", i, HGRANT); end
      total++; if (HMASTER !== 2'd3) begin bad++; $display("FAIL wait_master[%0d] got=%0d want=3", i, HMASTER); end
    end
    step(4'b1111, 4'b0000, 2'b11, 3'b011, 1'b1, 2'b00);
    step(4'b1111, 4'b0000, 2'b11, 3'b011, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b1000) begin bad++; $display("FAIL wait_beat3 got=%b want=1000", HGRANT); end
    step(4'b1111, 4'b0000, 2'b11, 3'b011, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0001) begin bad++; $display("FAIL wait_end got=%b want=0001", HGRANT); end
  endtask

  task automatic test_lock();
    step(4'b1111, 4'b0010, 2'b10, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0010) begin bad++; $display("FAIL lock_first got=%b want=0010", HGRANT); end
    total++; if (HMASTLOCK !== 1'b0) begin bad++; $display("FAIL lock_first_ml got=%b want=0", HMASTLOCK); end
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0010, 2'b10, 3'b000, 1'b1, 2'b00);
      total++; if (HGRANT !== 4'b0010) begin bad++; $display("FAIL lock_grant[%0d] got=%b want=0010", i, HGRANT); end
      total++; if (HMASTLOCK !== 1'b1) begin bad++; $display("FAIL lock_ml[%0d] got=%b want=1", i, HMASTLOCK); end
    end
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0100) begin bad++; $display("FAIL lock_release got=%b want=0100", HGRANT); end
  endtask

  task automatic test_early_term();
    step(4'b1111, 4'b0000, 2'b10, 3'b111, 1'b1, 2'b00);
    step(4'b1111, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00);
    step(4'b1111, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00);
    step(4'b1111, 4'b0000, 2'b11, 3'b111, 1'b0, 2'b01);
    total++; if (HGRANT !== 4'b0100) begin bad++; $display("FAIL err_first got=%b want=0100", HGRANT); end
    step(4'b1111, 4'b0000, 2'b00, 3'b111, 1'b1, 2'b01);
    total++; if (HGRANT !== 4'b1000) begin bad++; $display("FAIL err_regrant got=%b want=1000", HGRANT); end
    total++; if (HMASTER !== 2'd2) begin bad++; $display("FAIL err_master got=%0d want=2", HMASTER); end
  endtask

  task automatic test_park();
    for (int i = 0; i < 2; i++) begin
      step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
      total++; if (HGRANT !== 4'b0001) begin bad++; $display("FAIL park[%0d] got=%b want=0001", i, HGRANT); end
    end
    // Pointer still at 3, so master 0 wins next, then master 1.
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0001) begin bad++; $display("FAIL park_ptr got=%b want=0001", HGRANT); end
    step(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0010) begin bad++; $display("FAIL park_next got=%b want=0010", HGRANT); end
  endtask

  task automatic test_reset_mid_burst();
    step(4'b1111, 4'b0010, 2'b10, 3'b101, 1'b1, 2'b00);
    step(4'b1111, 4'b0010, 2'b11, 3'b101, 1'b1, 2'b00);
    step(4'b1111, 4'b0010, 2'b11, 3'b101, 1'b1, 2'b00);
    total++; if (HMASTLOCK !== 1'b1) begin bad++; $display("FAIL mid_ml got=%b want=1", HMASTLOCK); end
    HRESET = 1'b1;
    step(4'b1111, 4'b0010, 2'b11, 3'b101, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0001) begin bad++; $display("FAIL mid_rst_grant got=%b want=0001", HGRANT); end
    total++; if (HMASTER !== 2'd0) begin bad++; $display("FAIL mid_rst_master got=%0d want=0", HMASTER); end
    total++; if (HMASTLOCK !== 1'b0) begin bad++; $display("FAIL mid_rst_ml got=%b want=0", HMASTLOCK); end
    HRESET = 1'b0;
    step(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    total++; if (HGRANT !== 4'b0010) begin bad++; $display("FAIL post_rst_grant got=%b want=0010", HGRANT); end
  endtask

  task automatic test_random();
    logic [3:0] req, lk;
    logic [1:0] tr, rs;
    logic [2:0] bu;
    logic       rdy;
    HRESET = 1'b1;
    step(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    HRESET = 1'b0;
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom);
      lk  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      tr  = 2'($urandom);
      bu  = 3'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rs  = (!rdy && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      HRESET = ($urandom_range(0, 99) == 0);
      step(req, lk, tr, bu, rdy, rs);
      total++; if (HGRANT !== 4'(1 << m_grant)) begin bad++; $display("FAIL rnd_grant[%0d] got=%b want=%b", i, HGRANT, 4'(1 << m_grant)); end
      total++; if (HMASTER !== 2'(m_master)) begin bad++; $display("FAIL rnd_master[%0d] got=%0d want=%0d", i, HMASTER, m_master); end
      total++; if (HMASTLOCK !== m_mlock) begin bad++; $display("FAIL rnd_ml[%0d] got=%b want=%b", i, HMASTLOCK, m_mlock); end
      total++; if (!$onehot(HGRANT)) begin bad++; $display("FAIL rnd_onehot[%0d] got=%b want=onehot", i, HGRANT); end
    end
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = '0; HBURST = '0; HREADY = 1'b1; HRESP = '0;
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_wait_states();
    test_lock();
    test_early_term();
    test_park();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MST, default 4, meaning number of bus masters; the supported range SHALL be 2..4.
REQ-002 Port HCLK, input, 1 bit: system bus clock; all logic SHALL be clocked on the rising edge.
REQ-003 Port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port HBUSREQ, input, NUM_MST bits: bus request, one bit per master.
REQ-005 Port HLOCK, input, NUM_MST bits: locked-transfer request, one bit per master.
REQ-006 Port HTRANS, input, 2 bits: current transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-007 Port HBURST, input, 3 bits: current burst type (SINGLE=000, INCR=001, WRAP4/INCR4=01x, WRAP8/INCR8=10x, WRAP16/INCR16=11x).
REQ-008 Port HREADY, input, 1 bit: combined bus ready from the slave-to-master mux.
REQ-009 Port HRESP, input, 2 bits: combined response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
REQ-010 Port HGRANT, output, NUM_MST bits: registered one-hot grant.
REQ-011 Port HMASTER, output, 2 bits: registered index of the master that owns the current address phase.
REQ-012 Port HMASTLOCK, output, 1 bit: registered locked indication for the current address phase.

Function
REQ-013 HGRANT SHALL be exactly one-hot in every cycle.
REQ-014 The beat counter SHALL be 4 bits wide.
- Load: on HREADY=1 and HTRANS=NONSEQ, load 3, 7 or 15 for 4-, 8- or 16-beat bursts; load 0 for SINGLE or INCR.
- Decrement: on HREADY=1 and HTRANS=SEQ with counter > 0, decrement by 1.
- Hold: BUSY, or HREADY=0, SHALL hold the counter.
REQ-015 The counter SHALL clear to 0 in either of these cases:
- HREADY=0 and HRESP is ERROR, RETRY or SPLIT (early termination);
- HREADY=1 and HTRANS=IDLE.
REQ-016 incr_hold SHALL set on HREADY=1, HTRANS=NONSEQ, HBURST=INCR, and clear when the owning master drops HBUSREQ or on HREADY=1 with HTRANS=IDLE.
REQ-017 lock_hold SHALL equal HLOCK of the currently granted master.
REQ-018 rearb_ok SHALL be HREADY=1 AND next counter value = 0 AND incr_hold=0 AND lock_hold=0.
REQ-019 HGRANT SHALL update only at an edge where rearb_ok=1, and SHALL otherwise hold.
REQ-020 Arbitration SHALL be round-robin: the search starts at index ptr+1 (mod NUM_MST) and the first requester found wins.
- If no HBUSREQ bit is set, master 0 SHALL be granted (park).
REQ-021 The round-robin pointer SHALL update to the winner only when the winner had HBUSREQ set; a park grant SHALL NOT move it.
REQ-022 On an edge with HREADY=1:
- HMASTER SHALL load the index of the master granted in that cycle;
- HMASTLOCK SHALL load lock_hold.
- With HREADY=0, both SHALL hold.
REQ-023 A locked master SHALL retain the grant for as long as its HLOCK stays 1, regardless of other requests.
REQ-024 If HBUSREQ and rearb_ok coincide on the same edge, the new HGRANT SHALL be visible the following cycle, giving a 1-cycle grant latency.
REQ-025 HRESP=RETRY or SPLIT SHALL cause no masking of masters; the retried master SHALL re-arbitrate normally.
REQ-026 Request bits for indices >= NUM_MST SHALL be ignored.

Reset
REQ-027 With HRESET=1 at a rising HCLK edge, the block SHALL set:
- HGRANT=0001;
- HMASTER=0 and HMASTLOCK=0;
- pointer=0 and counter=0;
- incr_hold=0.
REQ-028 Reset SHALL take priority over every other update, including reset asserted mid-burst or mid-lock.
REQ-029 The first arbitration after reset deassertion SHALL start the search at master 1.

Verification
REQ-030 Round-robin: HBUSREQ=1111, single transfers, HREADY=1 -> HGRANT sequence 0010, 0100, 1000, 0001, with HMASTER following one cycle later.
REQ-031 Fixed burst: master 2 issues INCR8 (NONSEQ then 7 SEQ) while HBUSREQ=1111 -> HGRANT stays 0100 until the edge completing the 8th address, then changes to 1000.
REQ-032 Wait states: an INCR4 burst with HREADY=0 for 2 cycles on beat 2 -> counter holds, and HGRANT/HMASTER are unchanged until the burst completes.
REQ-033 Lock: master 1 has HLOCK=1 for 5 transfers while HBUSREQ=1111 -> HGRANT=0010 throughout and HMASTLOCK=1 from the second transfer; after HLOCK drops, the next grant is 0100.
REQ-034 Early termination: INCR16 with a 2-cycle ERROR response at beat 3 -> counter=0, and a new grant is issued on the ERROR completion edge.
REQ-035 Park and reset: HBUSREQ=0000 -> HGRANT=0001 and the pointer is unchanged; HRESET=1 mid-burst -> all outputs at reset values on the next cycle.
